// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq -- program-counter sequencer for the single-cycle MIPS datapath.
//
// Produces the registered instruction-memory word address each cycle. The next
// address comes from one of: sequential increment, PC-relative branch, absolute
// jump, subroutine call/return through a small return-address stack (RAS), or
// stall (hold). Priority: rst > stall > ret > call > jump > branch > increment.
// All PC arithmetic wraps modulo 2^ADDR_W.
//
// Configuration macro: PC_RAS_EN
//   defined   : RAS storage, call pushes addr+1, ret pops, sticky ovf/unf flags.
//   undefined : no RAS; call acts as jump, ret acts as increment,
//               ras_empty tied 1, ras_full/ras_ovf/ras_unf tied 0.
//
// Parameters:
//   ADDR_W     word-address width
//   RESET_ADDR address loaded on reset
//   RAS_DEPTH  return-address stack entries (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   stall      in   hold PC, RAS and flags; other controls ignored
//   branch     in   take PC-relative branch by branch_off
//   branch_off in   signed word offset (ADDR_W bits)
//   jump       in   absolute jump to jump_tgt
//   call       in   jump to jump_tgt and push addr+1
//   ret        in   pop RAS into PC
//   jump_tgt   in   absolute target for jump/call
//   addr       out  current PC (registered)
//   ras_empty  out  RAS holds no entries
//   ras_full   out  RAS holds RAS_DEPTH entries
//   ras_ovf    out  sticky: push while full
//   ras_unf    out  sticky: pop while empty
// -----------------------------------------------------------------------------
module pc_seq #(
    parameter int unsigned       ADDR_W     = 6,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int unsigned       RAS_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_tgt,
    output logic [ADDR_W-1:0] addr,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    if (RAS_DEPTH < 2) begin : g_depth_chk
        $error("pc_seq: RAS_DEPTH must be at least 2");
    end

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_br;
    logic [ADDR_W-1:0] w_next;

    // Same-width add: two's-complement wrap makes sign extension implicit.
    assign w_inc = r_addr + 1'b1;
    assign w_br  = r_addr + branch_off;
    assign addr  = r_addr;

`ifdef PC_RAS_EN
    localparam int unsigned      PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned      CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] TOP_MAX = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_unf;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_unf_evt;
    logic [PTR_W-1:0]  w_top_inc;
    logic [PTR_W-1:0]  w_top_dec;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_MAX);

    // Explicit wrap so non-power-of-two depths stay inside the array.
    assign w_top_inc = (r_top == TOP_MAX) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? TOP_MAX : r_top - 1'b1;

    always_comb begin
        w_next    = w_inc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_unf_evt = 1'b0;
        if (ret) begin
            // ret on an empty stack falls through to increment
            if (w_empty) begin
                w_unf_evt = 1'b1;
            end else begin
                w_next = r_stack[r_top];
                w_pop  = 1'b1;
            end
        end else if (call) begin
            w_next = jump_tgt;
            w_push = 1'b1;
        end else if (jump) begin
            w_next = jump_tgt;
        end else if (branch) begin
            w_next = w_br;
        end
    end

    // PC and RAS control state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= RESET_ADDR;
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (!stall) begin
            r_addr <= w_next;
            if (w_push) begin
                // When full, top+1 is the oldest slot: overwriting it drops it.
                r_top <= w_top_inc;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_top   <= w_top_dec;
                r_count <= r_count - 1'b1;
            end
            if (w_unf_evt) begin
                r_unf <= 1'b1;
            end
        end
    end

    // RAS storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (!rst && !stall && w_push) begin
            r_stack[w_top_inc] <= w_inc;
        end
    end

    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
`else
    always_comb begin
        w_next = w_inc;
        // ret without a stack is a plain increment and still outranks call/jump
        if (ret) begin
            w_next = w_inc;
        end else if (call || jump) begin
            w_next = jump_tgt;
        end else if (branch) begin
            w_next = w_br;
        end
    end

    // PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= RESET_ADDR;
        end else if (!stall) begin
            r_addr <= w_next;
        end
    end

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq -- self-checking bench for pc_seq (ADDR_W=6, RAS_DEPTH=4).
// Reference model: PC as an integer modulo 64, RAS as a queue of return
// addresses (newest at the back, oldest dropped from the front on overflow).
// -----------------------------------------------------------------------------
module tb_pc_seq;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;
    localparam int M      = 64;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall = 1'b0;
    logic              branch = 1'b0;
    logic [ADDR_W-1:0] branch_off = '0;
    logic              jump = 1'b0;
    logic              call = 1'b0;
    logic              ret = 1'b0;
    logic [ADDR_W-1:0] jump_tgt = '0;
    logic [ADDR_W-1:0] addr;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;
    logic              ras_unf;

    int n_tests = 0;
    int n_fail  = 0;

    int m_pc = 0;
    int m_ras[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    always #5 clk = ~clk;

    pc_seq #(
        .ADDR_W    (ADDR_W),
        .RESET_ADDR(6'd0),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .branch    (branch),
        .branch_off(branch_off),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .jump_tgt  (jump_tgt),
        .addr      (addr),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive on negedge, model on posedge, compare 1 time unit later.
    task automatic step(input bit s_rst, input bit s_stall, input bit s_br, input int s_off,
                        input bit s_jmp, input bit s_call, input bit s_ret, input int s_tgt);
        int soff;
        @(negedge clk);
        rst        = s_rst;
        stall      = s_stall;
        branch     = s_br;
        branch_off = 6'(s_off);
        jump       = s_jmp;
        call       = s_call;
        ret        = s_ret;
        jump_tgt   = 6'(s_tgt);
        @(posedge clk);
        soff = (s_off % M >= M / 2) ? (s_off % M) - M : (s_off % M);
        if (s_rst) begin
            m_pc = 0;
            m_ras.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (!s_stall) begin
            if (s_ret) begin
                if (RAS_EN && m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    m_pc = (m_pc + 1) % M;
                    if (RAS_EN) m_unf = 1'b1;
                end
            end else if (s_call) begin
                if (RAS_EN) begin
                    if (m_ras.size() == DEPTH) begin
                        void'(m_ras.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_ras.push_back((m_pc + 1) % M);
                end
                m_pc = s_tgt % M;
            end else if (s_jmp) begin
                m_pc = s_tgt % M;
            end else if (s_br) begin
                m_pc = (m_pc + soff + M) % M;
            end else begin
                m_pc = (m_pc + 1) % M;
            end
        end
        #1;
        chk("addr", 32'(addr), 32'(m_pc));
        chk("ras_empty", 32'(ras_empty), RAS_EN ? 32'(m_ras.size() == 0) : 32'd1);
        chk("ras_full", 32'(ras_full), RAS_EN ? 32'(m_ras.size() == DEPTH) : 32'd0);
        chk("ras_ovf", 32'(ras_ovf), 32'(m_ovf));
        chk("ras_unf", 32'(ras_unf), 32'(m_unf));
    endtask

    task automatic idle();            step(0, 0, 0, 0,   0, 0, 0, 0); endtask
    task automatic do_rst();          step(1, 0, 0, 0,   0, 0, 0, 0); endtask
    task automatic jmp(input int t);  step(0, 0, 0, 0,   1, 0, 0, t); endtask
    task automatic br(input int o);   step(0, 0, 1, o,   0, 0, 0, 0); endtask
    task automatic cal(input int t);  step(0, 0, 0, 0,   0, 1, 0, t); endtask
    task automatic rt();              step(0, 0, 0, 0,   0, 0, 1, 0); endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r_sel;

        // Reset then free-run
        do_rst();
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_empty", 32'(ras_empty), 32'd1);
        chk("rst_full", 32'(ras_full), 32'd0);
        chk("rst_ovf", 32'(ras_ovf), 32'd0);
        chk("rst_unf", 32'(ras_unf), 32'd0);
        idle(); chk("run1", 32'(addr), 32'd1);
        idle(); chk("run2", 32'(addr), 32'd2);
        idle(); chk("run3", 32'(addr), 32'd3);
        jmp(63); idle();
        chk("wrap63", 32'(addr), 32'd0);

        // Branch backward and forward with wrap
        jmp(10);
        br(6'h3B);
        chk("br_back", 32'(addr), 32'd5);
        jmp(62);
        br(4);
        chk("br_wrap", 32'(addr), 32'd2);

        // Call / return
        jmp(7);
        cal(40);
        chk("call_tgt", 32'(addr), 32'd40);
        chk("call_nonempty", 32'(ras_empty), RAS_EN ? 32'd0 : 32'd1);
        idle(); idle();
        rt();
        chk("ret_addr", 32'(addr), RAS_EN ? 32'd8 : 32'd43);
        chk("ret_empty", 32'(ras_empty), 32'd1);

        // Overflow: five nested calls from 1, 11, 21, 31, 41
        jmp(1);
        cal(10); idle();
        cal(20); idle();
        cal(30); idle();
        cal(40); idle();
        cal(50);
        chk("ovf_full", 32'(ras_full), 32'(RAS_EN));
        chk("ovf_flag", 32'(ras_ovf), 32'(RAS_EN));
        rt(); chk("ovf_ret1", 32'(addr), RAS_EN ? 32'd42 : 32'd51);
        rt(); chk("ovf_ret2", 32'(addr), RAS_EN ? 32'd32 : 32'd52);
        rt(); chk("ovf_ret3", 32'(addr), RAS_EN ? 32'd22 : 32'd53);
        rt(); chk("ovf_ret4", 32'(addr), RAS_EN ? 32'd12 : 32'd54);
        rt(); chk("unf_ret5", 32'(addr), RAS_EN ? 32'd13 : 32'd55);
        chk("unf_flag", 32'(ras_unf), 32'(RAS_EN));

        // Stall outranks branch and ret; call taken once released
        do_rst();
        jmp(5);
        cal(20);
        step(0, 1, 1, 3, 0, 0, 1, 0);
        step(0, 1, 1, 3, 0, 0, 1, 0);
        step(0, 1, 1, 3, 0, 0, 1, 0);
        chk("stall_addr", 32'(addr), 32'd20);
        chk("stall_ras", 32'(ras_empty), RAS_EN ? 32'd0 : 32'd1);
        step(0, 0, 0, 0, 0, 1, 0, 33);
        chk("stall_release_call", 32'(addr), 32'd33);

        // Reset mid-operation with two entries on the stack
        do_rst();
        chk("mid_rst_addr", 32'(addr), 32'd0);
        chk("mid_rst_empty", 32'(ras_empty), 32'd1);
        chk("mid_rst_ovf", 32'(ras_ovf), 32'd0);
        chk("mid_rst_unf", 32'(ras_unf), 32'd0);
        rt();
        chk("mid_rst_ret_addr", 32'(addr), 32'd1);
        chk("mid_rst_ret_unf", 32'(ras_unf), 32'(RAS_EN));

        // Randomized mix of all controls
        for (int i = 0; i < 500; i++) begin
            r_sel = int'($urandom_range(0, 99));
            step(r_sel < 2,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 63)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 63)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the single-cycle MIPS datapath; successor to the fixed 6-bit free-running counter. Produces the registered instruction-memory word address each cycle and selects between sequential increment, PC-relative branch, absolute jump, subroutine call/return through a small return-address stack (RAS), and stall. Sits between the control unit and the instruction memory.

## Interface
- ADDR_W, 6: word-address width; all PC arithmetic is modulo 2^ADDR_W.
- RESET_ADDR, 0: value loaded into addr on reset.
- RAS_DEPTH, 4: return-address stack entries (≥2).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and RAS; all other controls ignored.
- branch  in  1  take PC-relative branch.
- branch_off  in  ADDR_W  signed two's-complement word offset.
- jump  in  1  take absolute jump.
- call  in  1  jump to jump_tgt and push addr+1.
- ret  in  1  pop RAS into PC.
- jump_tgt  in  ADDR_W  absolute target for jump/call.
- addr  out  ADDR_W  current PC (registered).
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: push attempted while full.
- ras_unf  out  1  sticky: pop attempted while empty.

## Operation
- Next-PC priority, evaluated each cycle: rst > stall > ret > call > jump > branch > increment.
- increment: addr ← addr+1. branch: addr ← addr+branch_off (sign-extended, wraps). jump: addr ← jump_tgt.
- call: addr ← jump_tgt; push addr+1 (wrapped). Lower-priority requests in same cycle ignored.
- ret with RAS non-empty: addr ← top entry; pop. ret with RAS empty: addr ← addr+1, ras_unf set, count unchanged.
- call with RAS full: oldest entry discarded (circular overwrite), new entry becomes top, count stays RAS_DEPTH, ras_ovf set.
- call and ret same cycle: ret wins; no push.
- RAS state: count 0..RAS_DEPTH, top pointer modulo RAS_DEPTH. ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both combinational from registered count.
- Sticky flags clear only on rst.

## Timing
- Reset (rst high at edge): addr=RESET_ADDR, count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. Reset mid-operation discards all RAS contents in that edge.
- Controls sampled at rising edge; addr reflects decision one cycle later (latency 1). Flags update same edge as the causing push/pop.
- First instruction after reset deasserts: addr=RESET_ADDR for one cycle, then RESET_ADDR+1 absent other controls.
- stall: addr, RAS, flags unchanged for every stalled cycle; request must be re-presented after stall.
- Wrap-around: addr=2^ADDR_W−1 increments to 0; branch/call return address wrap identically.

## Configuration
- PC_RAS_EN defined: RAS, call/ret behaviour and flags as above.
- PC_RAS_EN undefined: no RAS storage; call behaves as jump; ret behaves as increment; ras_empty tied 1, ras_full/ras_ovf/ras_unf tied 0.

## Test plan
- Reset then free-run (ADDR_W=6): rst high one edge → addr=0, then 1,2,3 on successive edges; from 63 next is 0.
- Branch: at addr=10 assert branch, branch_off=6'h3B (−5) → addr=5; at addr=62 branch_off=+4 → addr=2.
- Call/ret: at addr=7 call, jump_tgt=40 → addr=40, ras_empty=0; two increments, ret → addr=8, ras_empty=1.
- Overflow (RAS_DEPTH=4): five nested calls from addrs 1,11,21,31,41 → ras_full=1, ras_ovf=1; four rets return 42,32,22,12; fifth ret → addr+1, ras_unf=1.
- Stall priority: stall with branch and ret asserted at addr=20 for 3 cycles → addr stays 20, RAS count unchanged; stall released with call asserted → call taken.
- Reset mid-operation: after two calls (count=2) assert rst → addr=RESET_ADDR, ras_empty=1, flags 0; subsequent ret → ras_unf=1, addr increments.
